// File: rtl/deserializer_pkg.sv
// Shared router package: beat widths, header field offsets, flag values and
// the receive state type. The serializer packs beats with the same offsets.
package deserializer_pkg;

  localparam int NUMER_OF_LANE          = 1;
  localparam int AURORA_DATA_WIDTH      = 64 * NUMER_OF_LANE;
  localparam int RECV_DATA_WIDTH        = 1024;
  localparam int RECOGNIZE_HEADER_WIDTH = 1;
  localparam int RECOGNIZE_ROUTER_WIDTH = 2;
  localparam int HOST_PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - 3;
  localparam int NUMBER_PACKET          = RECV_DATA_WIDTH / HOST_PAYLOAD_WIDTH + 1;
  localparam int ADDR_WIDTH             = 10;
  localparam int TTL_WIDTH              = 2;

  // Reassembly buffer covers every payload frame, padding included.
  localparam int BUF_WIDTH         = NUMBER_PACKET * HOST_PAYLOAD_WIDTH;
  localparam int FRAME_COUNT_WIDTH = $clog2(NUMBER_PACKET + 1);

  // Beat field offsets.
  localparam int FLAG_LSB    = 0;
  localparam int ROUTER_LSB  = FLAG_LSB + RECOGNIZE_HEADER_WIDTH;
  localparam int DST_LSB     = ROUTER_LSB + RECOGNIZE_ROUTER_WIDTH;
  localparam int TTL_LSB     = DST_LSB + ADDR_WIDTH;
  localparam int PAYLOAD_LSB = ROUTER_LSB + RECOGNIZE_ROUTER_WIDTH;

  localparam logic HDR_FLAG     = 1'b1;
  localparam logic PAYLOAD_FLAG = 1'b0;

  typedef enum logic {
    S_IDLE,
    S_PAYLOAD
  } state_t;

endpackage

// File: rtl/deserializer_if.sv
// Aurora RX AXI-Stream beat interface (no tready: every valid beat is taken).
interface deserializer_if;

  logic                                          axis_rx_tvalid;
  logic                                          axis_rx_tlast;
  logic [deserializer_pkg::AURORA_DATA_WIDTH-1:0] axis_rx_tdata;

  modport master (
    output axis_rx_tvalid,
    output axis_rx_tlast,
    output axis_rx_tdata
  );

  modport slave (
    input axis_rx_tvalid,
    input axis_rx_tlast,
    input axis_rx_tdata
  );

endinterface

// File: rtl/deser_frame_decode.sv
// Combinational field extraction from one Aurora beat: header flag, source
// router, header destination/TTL and the payload slice.
module deser_frame_decode
  import deserializer_pkg::*;
(
  input  logic [AURORA_DATA_WIDTH-1:0]  beat,
  output logic                          is_header,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] src_router,
  output logic [ADDR_WIDTH-1:0]         dst_addr,
  output logic [TTL_WIDTH-1:0]          ttl,
  output logic [HOST_PAYLOAD_WIDTH-1:0] payload
);

  assign is_header  = (beat[FLAG_LSB] == HDR_FLAG);
  assign src_router = beat[ROUTER_LSB +: RECOGNIZE_ROUTER_WIDTH];
  assign dst_addr   = beat[DST_LSB +: ADDR_WIDTH];
  assign ttl        = beat[TTL_LSB +: TTL_WIDTH];
  assign payload    = beat[PAYLOAD_LSB +: HOST_PAYLOAD_WIDTH];

endmodule

// File: rtl/deserializer.sv
// Aurora RX deserializer: one header beat followed by NUMBER_PACKET payload
// beats is rebuilt into a 1024-bit word plus routing fields, presented with a
// one-cycle recv_data_valid pulse. Protocol violations pulse frame_error.
// Optional build macro DESER_SRC_CHECK_EN: payload beats must carry the same
// source router id as their header, otherwise the message is dropped.
module deserializer
  import deserializer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  deserializer_if.slave              rx,
  output logic                       recv_data_valid,
  output logic [RECV_DATA_WIDTH-1:0] v_data_recv,
  output logic [ADDR_WIDTH-1:0]      dst_addr_recv,
  output logic [TTL_WIDTH-1:0]       TTL_recv,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic                       frame_error
);

  localparam logic [FRAME_COUNT_WIDTH-1:0] LAST_FRAME = FRAME_COUNT_WIDTH'(NUMBER_PACKET - 1);

  logic                              is_header;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] src_router;
  logic [ADDR_WIDTH-1:0]             dst_addr;
  logic [TTL_WIDTH-1:0]              ttl;
  logic [HOST_PAYLOAD_WIDTH-1:0]     payload;

  state_t                            state_reg, state_next;
  logic [FRAME_COUNT_WIDTH-1:0]      count_reg, count_next;
  logic [ADDR_WIDTH-1:0]             dst_shadow_reg;
  logic [TTL_WIDTH-1:0]              ttl_shadow_reg;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid_shadow_reg;
  logic [BUF_WIDTH-1:0]              buf_reg, buf_merged;

  logic capture_hdr, write_en, complete, error_next, src_mismatch;

  deser_frame_decode u_decode (
    .beat       (rx.axis_rx_tdata),
    .is_header  (is_header),
    .src_router (src_router),
    .dst_addr   (dst_addr),
    .ttl        (ttl),
    .payload    (payload)
  );

`ifdef DESER_SRC_CHECK_EN
  assign src_mismatch = (src_router != rid_shadow_reg);
`else
  logic unused_src_router;
  assign src_mismatch      = 1'b0;
  assign unused_src_router = ^src_router;
`endif

  // Buffer with the current beat's slice merged in, so the final slice can go
  // straight to the output on the completing edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_PACKET; gi++) begin : g_slice
      localparam logic [FRAME_COUNT_WIDTH-1:0] IDX = FRAME_COUNT_WIDTH'(gi);
      assign buf_merged[gi*HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH] =
        (write_en && (count_reg == IDX)) ? payload
                                         : buf_reg[gi*HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH];
    end
  endgenerate

  // Next-state and control decode for the header/payload sequencer.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    capture_hdr = 1'b0;
    write_en    = 1'b0;
    complete    = 1'b0;
    error_next  = 1'b0;
    if (rx.axis_rx_tvalid) begin
      unique case (state_reg)
        S_IDLE: begin
          if (is_header) begin
            capture_hdr = 1'b1;
            count_next  = '0;
            state_next  = S_PAYLOAD;
          end else begin
            error_next = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (is_header) begin
            // Restart: the partial message is abandoned, this beat is the new header.
            error_next  = 1'b1;
            capture_hdr = 1'b1;
            count_next  = '0;
          end else if (src_mismatch) begin
            error_next = 1'b1;
            state_next = S_IDLE;
          end else if (count_reg == LAST_FRAME) begin
            state_next = S_IDLE;
            if (rx.axis_rx_tlast) begin
              write_en = 1'b1;
              complete = 1'b1;
            end else begin
              error_next = 1'b1;
            end
          end else if (rx.axis_rx_tlast) begin
            error_next = 1'b1;
            state_next = S_IDLE;
          end else begin
            write_en   = 1'b1;
            count_next = count_reg + FRAME_COUNT_WIDTH'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Sequencer state, frame counter, header shadows and reassembly buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      count_reg      <= '0;
      dst_shadow_reg <= '0;
      ttl_shadow_reg <= '0;
      rid_shadow_reg <= '0;
      buf_reg        <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      buf_reg   <= buf_merged;
      if (capture_hdr) begin
        dst_shadow_reg <= dst_addr;
        ttl_shadow_reg <= ttl;
        rid_shadow_reg <= src_router;
      end
    end
  end

  // Output registers: pulses every cycle, message fields only on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recv_data_valid <= 1'b0;
      frame_error     <= 1'b0;
      v_data_recv     <= '0;
      dst_addr_recv   <= '0;
      TTL_recv        <= '0;
      router_id_recv  <= '0;
    end else begin
      recv_data_valid <= complete;
      frame_error     <= error_next;
      if (complete) begin
        v_data_recv    <= buf_merged[RECV_DATA_WIDTH-1:0];
        dst_addr_recv  <= dst_shadow_reg;
        TTL_recv       <= ttl_shadow_reg;
        router_id_recv <= rid_shadow_reg;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: good messages, gaps, back-to-back,
// protocol errors and mid-message reset.
module tb_deserializer;
  import deserializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deserializer_if rx ();

  logic                 recv_data_valid;
  logic [1023:0]        v_data_recv;
  logic [9:0]           dst_addr_recv;
  logic [1:0]           TTL_recv;
  logic [1:0]           router_id_recv;
  logic                 frame_error;

  deserializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx              (rx),
    .recv_data_valid (recv_data_valid),
    .v_data_recv     (v_data_recv),
    .dst_addr_recv   (dst_addr_recv),
    .TTL_recv        (TTL_recv),
    .router_id_recv  (router_id_recv),
    .frame_error     (frame_error)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_drive_cyc = 0;

  logic [1023:0] pattern;
  logic [1023:0] fives;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (recv_data_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (frame_error === 1'b1) err_cnt++;
  end

  // Payload beat k: {data[k*61 +: 61], router, 0}; padding above bit 1023 is zero.
  function automatic logic [63:0] pbeat(input logic [1023:0] d, input int k, input logic [1:0] r);
    logic [BUF_WIDTH-1:0] e;
    e = BUF_WIDTH'(d);
    return {e[k*61 +: 61], r, 1'b0};
  endfunction

  task automatic drive(input logic v, input logic l, input logic [63:0] d);
    @(negedge clk);
    rx.axis_rx_tvalid = v;
    rx.axis_rx_tlast  = l;
    rx.axis_rx_tdata  = d;
    last_drive_cyc    = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {$urandom, $urandom});
  endtask

  task automatic send_payloads(input logic [1023:0] d, input logic [1:0] r, input int first,
                               input int last, input int tlast_k, input bit gaps);
    for (int k = first; k <= last; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      drive(1'b1, k == tlast_k, pbeat(d, k, r));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++; if (recv_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", recv_data_valid); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_error); end
    total++; if (v_data_recv !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", v_data_recv); end
    total++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== 14'h0) begin
      bad++; $display("FAIL reset_fields got=%h/%h/%h exp=0/0/0", dst_addr_recv, TTL_recv, router_id_recv);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int v0, e0, fin;
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 16, 16, 1'b0);
    fin = last_drive_cyc;
    idle(3);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", valid_cnt - v0); end
    total++; if (last_valid_cyc !== fin + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", last_valid_cyc, fin + 1); end
    total++; if (v_data_recv !== pattern) begin bad++; $display("FAIL basic_data got=%h exp=%h", v_data_recv, pattern); end
    total++; if (dst_addr_recv !== 10'h00A) begin bad++; $display("FAIL basic_dst got=%h exp=00a", dst_addr_recv); end
    total++; if (TTL_recv !== 2'd1) begin bad++; $display("FAIL basic_ttl got=%0d exp=1", TTL_recv); end
    total++; if (router_id_recv !== 2'd2) begin bad++; $display("FAIL basic_rid got=%0d exp=2", router_id_recv); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL basic_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_gaps();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    idle(2);
    drive(1'b1, 1'b0, 64'h4D57);
    send_payloads(fives, 2'd3, 0, 16, 16, 1'b1);
    idle(4);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL gaps_pulses got=%0d exp=1", valid_cnt - v0); end
    total++; if (v_data_recv !== fives) begin bad++; $display("FAIL gaps_data got=%h exp=%h", v_data_recv, fives); end
    total++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== {10'h1AA, 2'd2, 2'd3}) begin
      bad++; $display("FAIL gaps_fields got=%h/%h/%h exp=1aa/2/3", dst_addr_recv, TTL_recv, router_id_recv);
    end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL gaps_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 16, 16, 1'b0);
    drive(1'b1, 1'b0, 64'h4D57);
    send_payloads(fives, 2'd3, 0, 16, 16, 1'b0);
    idle(3);
    total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", valid_cnt - v0); end
    total++; if (last_valid_cyc - prev_valid_cyc !== 18) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=18", last_valid_cyc - prev_valid_cyc);
    end
    total++; if (v_data_recv !== fives) begin bad++; $display("FAIL b2b_data got=%h exp=%h", v_data_recv, fives); end
    total++; if (dst_addr_recv !== 10'h1AA) begin bad++; $display("FAIL b2b_dst got=%h exp=1aa", dst_addr_recv); end
  endtask

  task automatic test_early_tlast();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    // tlast on frame 5
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 5, 5, 1'b0);
    idle(3);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL early_err got=%0d exp=1", err_cnt - e0); end
    // stray payload while idle
    drive(1'b1, 1'b0, pbeat(pattern, 0, 2'd2));
    idle(3);
    total++; if (err_cnt - e0 !== 2) begin bad++; $display("FAIL idle_payload_err got=%0d exp=2", err_cnt - e0); end
    // final frame without tlast
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 16, -1, 1'b0);
    idle(3);
    total++; if (err_cnt - e0 !== 3) begin bad++; $display("FAIL notlast_err got=%0d exp=3", err_cnt - e0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL early_nopulse got=%0d exp=0", valid_cnt - v0); end
    total++; if (v_data_recv !== fives) begin bad++; $display("FAIL early_hold got=%h exp=%h", v_data_recv, fives); end
    // following good message
    drive(1'b1, 1'b0, 64'h4D57);
    send_payloads(~pattern, 2'd3, 0, 16, 16, 1'b0);
    idle(3);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL early_recover_pulses got=%0d exp=1", valid_cnt - v0); end
    total++; if (v_data_recv !== ~pattern) begin bad++; $display("FAIL early_recover_data got=%h exp=%h", v_data_recv, ~pattern); end
  endtask

  task automatic test_new_header();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b1, 1'b0, 64'h4D57);
    send_payloads(fives, 2'd3, 0, 8, -1, 1'b0);
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 16, 16, 1'b0);
    idle(3);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL newhdr_err got=%0d exp=1", err_cnt - e0); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL newhdr_pulses got=%0d exp=1", valid_cnt - v0); end
    total++; if (v_data_recv !== pattern) begin bad++; $display("FAIL newhdr_data got=%h exp=%h", v_data_recv, pattern); end
    total++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== {10'h00A, 2'd1, 2'd2}) begin
      bad++; $display("FAIL newhdr_fields got=%h/%h/%h exp=00a/1/2", dst_addr_recv, TTL_recv, router_id_recv);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    drive(1'b1, 1'b0, 64'h2055);
    send_payloads(pattern, 2'd2, 0, 7, -1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx.axis_rx_tvalid = 1'b0;
    @(negedge clk);
    total++; if ({recv_data_valid, frame_error} !== 2'b00) begin
      bad++; $display("FAIL midrst_pulses got=%b%b exp=00", recv_data_valid, frame_error);
    end
    total++; if (v_data_recv !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", v_data_recv); end
    total++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== 14'h0) begin
      bad++; $display("FAIL midrst_fields got=%h/%h/%h exp=0/0/0", dst_addr_recv, TTL_recv, router_id_recv);
    end
    rst_n = 1'b1;
    v0 = valid_cnt;
    drive(1'b1, 1'b0, 64'h4D57);
    send_payloads(fives, 2'd3, 0, 16, 16, 1'b0);
    idle(3);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL midrst_pulse_after got=%0d exp=1", valid_cnt - v0); end
    total++; if (v_data_recv !== fives) begin bad++; $display("FAIL midrst_data_after got=%h exp=%h", v_data_recv, fives); end
    total++; if ({dst_addr_recv, TTL_recv, router_id_recv} !== {10'h1AA, 2'd2, 2'd3}) begin
      bad++; $display("FAIL midrst_fields_after got=%h/%h/%h exp=1aa/2/3", dst_addr_recv, TTL_recv, router_id_recv);
    end
  endtask

  task automatic test_src_router();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b1, 1'b0, 64'h2055);
`ifdef DESER_SRC_CHECK_EN
    send_payloads(pattern, 2'd2, 0, 2, -1, 1'b0);
    drive(1'b1, 1'b0, pbeat(pattern, 3, 2'd1));
    idle(3);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL srcchk_err got=%0d exp=1", err_cnt - e0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL srcchk_nopulse got=%0d exp=0", valid_cnt - v0); end
`else
    // Payload router bits differ from the header and are ignored.
    send_payloads(~fives, 2'd1, 0, 16, 16, 1'b0);
    idle(3);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL srcign_err got=%0d exp=0", err_cnt - e0); end
    total++; if (v_data_recv !== ~fives) begin bad++; $display("FAIL srcign_data got=%h exp=%h", v_data_recv, ~fives); end
    total++; if (router_id_recv !== 2'd2) begin bad++; $display("FAIL srcign_rid got=%0d exp=2", router_id_recv); end
`endif
  endtask

  initial begin
    // Pattern read MSB first: 1111 2222 ... 9999 1111 ... repeated over 256 nibbles.
    for (int i = 0; i < 256; i++) pattern[1023 - i*4 -: 4] = 4'((i / 4) % 9 + 1);
    fives = {256{4'h5}};
    rx.axis_rx_tvalid = 1'b0;
    rx.axis_rx_tlast  = 1'b0;
    rx.axis_rx_tdata  = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_early_tlast();
    test_new_header();
    test_reset_mid();
    test_src_router();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Receive-side counterpart of the router's Aurora serializer. Consumes the 64-bit Aurora AXI-Stream RX beat stream: one header frame followed by NUMBER_PACKET payload frames. Rebuilds the 1024-bit data word and its routing fields, then presents them to the router core with a single-cycle valid pulse. Sits between the Aurora RX user interface and the router's input buffer/switch logic.

Parameters:
- NUMER_OF_LANE, 1, Aurora lanes.
- AURORA_DATA_WIDTH, 64*NUMER_OF_LANE, beat width.
- RECV_DATA_WIDTH, 1024, reassembled data width.
- RECOGNIZE_HEADER_WIDTH, 1, header/payload flag width.
- RECOGNIZE_ROUTER_WIDTH, 2, source-router field width.
- HOST_PAYLOAD_WIDTH, AURORA_DATA_WIDTH-3 (=61), payload bits per frame.
- NUMBER_PACKET, RECV_DATA_WIDTH/HOST_PAYLOAD_WIDTH+1 (=17), payload frames per message.
- ADDR_WIDTH, 10, destination address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- axis_rx_tvalid  in  1  beat valid. No tready; every valid beat must be consumed.
- axis_rx_tlast  in  1  last beat of message.
- axis_rx_tdata  in  AURORA_DATA_WIDTH  beat.
- recv_data_valid  out  1  one-cycle pulse: message complete.
- v_data_recv  out  RECV_DATA_WIDTH  reassembled data.
- dst_addr_recv  out  ADDR_WIDTH  header destination address.
- TTL_recv  out  2  header TTL.
- router_id_recv  out  2  header source router id.
- frame_error  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Beat format: bit[0]=1 marks a header, bit[0]=0 marks a payload. bits[2:1] carry the source router. Header: bits[12:3]=dst_addr, bits[14:13]=TTL, rest zero. Payload k (0..16): bits[63:3] = data[k*61 +: 61]. The final frame's upper 13 bits are padding and are discarded.
- Reset: all outputs and internal registers go to 0; the state machine goes to S_IDLE. Reset mid-message discards any partial data.
- States:
  - S_IDLE: a valid beat with bit0=1 captures the header fields into shadow registers, clears frame_count, and moves to S_PAYLOAD. A valid payload beat in S_IDLE pulses frame_error and is dropped.
  - S_PAYLOAD: each valid payload beat writes its 61-bit slice at frame_count*61, then frame_count increments.
- When the beat with frame_count==NUMBER_PACKET-1 arrives with tlast=1:
  - next cycle: recv_data_valid=1.
  - v_data_recv, dst_addr_recv, TTL_recv and router_id_recv update from the shadow registers on that same edge and hold until the next completion.
  - state returns to S_IDLE.
- Latency: recv_data_valid rises one cycle after the final beat.
- Back-to-back messages: a header arriving in the cycle right after the final beat is accepted normally.
- Errors in S_PAYLOAD: each pulses frame_error for one cycle; outputs and recv_data_valid are unaffected.
  - tlast=1 before the final frame: drop the message, go to S_IDLE.
  - final frame without tlast: drop the message, go to S_IDLE.
  - header beat (bit0=1): drop the partial message and treat the beat as a new header, staying in S_PAYLOAD with frame_count=0.
- tvalid=0 cycles in any state: hold state; no timeout.
- frame_count width is $clog2(NUMBER_PACKET+1) and never wraps.

Optional Feature:
- Macro: DESER_SRC_CHECK_EN.
- Defined: every payload beat's bits[2:1] must equal the captured header router id. A mismatch is a protocol error: pulse frame_error, drop the message, go to S_IDLE.
- Undefined: payload bits[2:1] are ignored.

Decomposition:
- Shared router package: width constants (AURORA_DATA_WIDTH, HOST_PAYLOAD_WIDTH, NUMBER_PACKET, ADDR_WIDTH), header field bit offsets, the HDR/PAYLOAD flag constant, and the state enum typedef. The serializer uses the same offsets.
- One sub-module, deser_frame_decode: combinational field extraction (is_header, src_router, dst_addr, TTL, payload slice) from a beat.

Test Plan:
- Header 64'h2055 (dst 0x00A, TTL 1, router 2), then 17 payload frames slicing the 1024-bit 1111_2222…9999 pattern, tlast on the 17th -> one cycle later recv_data_valid=1, v_data_recv equals the pattern, dst=0x00A, TTL=1, router=2.
- Header 64'h4D57 (dst 0x1AA, TTL 2, router 3) plus an all-5s payload, with random tvalid gaps -> identical reassembly; valid pulse exactly once.
- Two messages back-to-back with no idle cycle -> two recv_data_valid pulses, 18 cycles apart.
- tlast on payload frame 5 -> frame_error pulse, no recv_data_valid; the following good message is received correctly.
- New header at frame 9 -> frame_error pulse; the new message completes with the new header's fields.
- rst_n=0 for one cycle at frame 8, then a full message -> outputs are 0 after reset, and the full message is received correctly (with DESER_SRC_CHECK_EN, a router-id mismatch on frame 3 also gives frame_error).
